paddle_mover: RTL and testbench

- Parametrised paddle position controller for the two-player pong game on the 320x240 VGA canvas.
- Moves one paddle up or down by STEP pixels per request and clamps the paddle to the screen.
- Auto-repeats while a move is held.
- Hands each new position to the drawing datapath through a req/ack handshake, so the old paddle is erased and the new one drawn before the next step.
- One instance per player; it sits between the keyboard/switch decode and the VGA draw FSM.

---
 rtl/game_pkg.sv | 21 ++
 rtl/paddle_mover_if.sv | 28 ++
 rtl/paddle_step_calc.sv | 43 ++++
 rtl/paddle_mover.sv | 133 +++++++++++++
 tb/tb_paddle_mover.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared constants and types for the pong game blocks: canvas size, paddle
// defaults, paddle FSM state encoding and move direction codes.
package game_pkg;

    localparam int CANVAS_W     = 320;
    localparam int CANVAS_H     = 240;
    localparam int PADDLE_H_DEF = 10;
    localparam int X_LEFT_DEF   = 0;
    localparam int X_RIGHT_DEF  = 310;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DRAW = 2'd2,
        ST_HOLD = 2'd3
    } paddle_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/paddle_mover_if.sv
// Signal bundle between the key decode / VGA draw FSM and one paddle mover.
interface paddle_mover_if #(
    parameter int X_W = 9,
    parameter int Y_W = 8
);
    logic           player;
    logic           move_req;
    logic           dir;
    logic           draw_ack;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [Y_W-1:0] old_y;
    logic           draw_req;
    logic           at_top;
    logic           at_bottom;
    logic           busy;

    modport master (
        output player, move_req, dir, draw_ack,
        input  x, y, old_y, draw_req, at_top, at_bottom, busy
    );

    modport slave (
        input  player, move_req, dir, draw_ack,
        output x, y, old_y, draw_req, at_top, at_bottom, busy
    );

endinterface

// File: rtl/paddle_step_calc.sv
// Combinational one-step move of a vertical coordinate, clamped to [0, Y_MAX].
// Also reused by the ball logic.
module paddle_step_calc
    import game_pkg::*;
#(
    parameter int Y_W   = 8,
    parameter int STEP  = 10,
    parameter int Y_MAX = 230
) (
    input  logic [Y_W-1:0] y,
    input  logic           dir,
    output logic [Y_W-1:0] y_next
);

    localparam logic [Y_W:0] STEP_E  = (Y_W+1)'(STEP);
    localparam logic [Y_W:0] Y_MAX_E = (Y_W+1)'(Y_MAX);

    logic [Y_W:0] y_ext;
    logic [Y_W:0] sum;
    logic [Y_W:0] diff;

    // One extra bit keeps y+STEP from wrapping before the clamp compare.
    always_comb begin
        y_ext  = {1'b0, y};
        sum    = y_ext + STEP_E;
        diff   = y_ext - STEP_E;
        y_next = y;
        if (dir == DIR_DOWN) begin
            if (sum > Y_MAX_E) begin
                y_next = Y_W'(Y_MAX_E);
            end else begin
                y_next = Y_W'(sum);
            end
        end else begin
            if (y_ext < STEP_E) begin
                y_next = '0;
            end else begin
                y_next = Y_W'(diff);
            end
        end
    end

endmodule

// File: rtl/paddle_mover.sv
// Paddle position controller: steps one paddle per request with auto-repeat,
// clamps to the canvas and hands every new position to the draw FSM.
module paddle_mover
    import game_pkg::*;
#(
    parameter int SCREEN_H     = CANVAS_H,
    parameter int PADDLE_H     = PADDLE_H_DEF,
    parameter int STEP         = 10,
    parameter int X_LEFT       = X_LEFT_DEF,
    parameter int X_RIGHT      = X_RIGHT_DEF,
    parameter int Y_INIT       = 115,
    parameter int REPEAT_TICKS = 5000000,
    parameter int X_W          = 9,
    parameter int Y_W          = 8
) (
    input logic           clock,
    input logic           reset,
    paddle_mover_if.slave bus
);

    localparam int             Y_MAX    = SCREEN_H - PADDLE_H;
    localparam int             CNT_W    = $clog2(REPEAT_TICKS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [X_W-1:0] X_L      = X_W'(X_LEFT);
    localparam logic [X_W-1:0] X_R      = X_W'(X_RIGHT);
    localparam logic [Y_W-1:0] Y_START  = Y_W'(Y_INIT);
    localparam logic [Y_W-1:0] Y_LIMIT  = Y_W'(Y_MAX);

    paddle_state_t    state;
    paddle_state_t    state_nx;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [Y_W-1:0]   old_y_q;
    logic [Y_W-1:0]   y_step;
    logic             dir_q;
    logic [CNT_W-1:0] cnt;
    logic             top_w;
    logic             bottom_w;
    logic             blocked;
    logic             load_x;
    logic             latch_dir;
    logic             take_step;
    logic             load_cnt;
    logic             dec_cnt;

    paddle_step_calc #(
        .Y_W   (Y_W),
        .STEP  (STEP),
        .Y_MAX (Y_MAX)
    ) u_step (
        .y      (y_q),
        .dir    (dir_q),
        .y_next (y_step)
    );

    assign top_w    = (y_q == '0);
    assign bottom_w = (y_q == Y_LIMIT);

    // A request pushing into the edge it already touches never leaves IDLE.
    always_comb begin
        state_nx  = state;
        load_x    = 1'b0;
        latch_dir = 1'b0;
        take_step = 1'b0;
        load_cnt  = 1'b0;
        dec_cnt   = 1'b0;
        blocked   = (bus.dir == DIR_DOWN) ? bottom_w : top_w;
        case (state)
            ST_IDLE: begin
                load_x = 1'b1;
                if (bus.move_req && !blocked) begin
                    latch_dir = 1'b1;
                    state_nx  = ST_STEP;
                end
            end
            ST_STEP: begin
                take_step = 1'b1;
                state_nx  = ST_DRAW;
            end
            ST_DRAW: begin
                if (bus.draw_ack) begin
                    load_cnt = 1'b1;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!bus.move_req || cnt == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            x_q     <= bus.player ? X_R : X_L;
            y_q     <= Y_START;
            old_y_q <= Y_START;
            dir_q   <= DIR_UP;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (load_x) begin
                x_q <= bus.player ? X_R : X_L;
            end
            if (latch_dir) begin
                dir_q <= bus.dir;
            end
            if (take_step) begin
                old_y_q <= y_q;
                y_q     <= y_step;
            end
            if (load_cnt) begin
                cnt <= CNT_LOAD;
            end else if (dec_cnt) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.old_y     = old_y_q;
    assign bus.draw_req  = (state == ST_DRAW);
    assign bus.at_top    = top_w;
    assign bus.at_bottom = bottom_w;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_paddle_mover.sv
// Directed bench for paddle_mover: expected positions are queued when a move is
// issued and checked when the DUT raises draw_req.
module tb_paddle_mover;

    localparam int SCREEN_H     = 240;
    localparam int PADDLE_H     = 10;
    localparam int STEP         = 10;
    localparam int Y_MAX        = SCREEN_H - PADDLE_H;
    localparam int REPEAT_TICKS = 4;

    typedef struct {
        int y_exp;
        int old_exp;
    } exp_t;

    logic clock;
    logic reset;
    int   n_compared;
    int   n_mismatched;
    int   cyc;
    int   mdl_y;
    exp_t sb_q[$];

    paddle_mover_if #(.X_W(9), .Y_W(8)) bus ();

    paddle_mover #(
        .SCREEN_H     (SCREEN_H),
        .PADDLE_H     (PADDLE_H),
        .STEP         (STEP),
        .X_LEFT       (0),
        .X_RIGHT      (310),
        .Y_INIT       (115),
        .REPEAT_TICKS (REPEAT_TICKS),
        .X_W          (9),
        .Y_W          (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int model_next(input int yv, input logic d);
        if (d) return (yv + STEP > Y_MAX) ? Y_MAX : yv + STEP;
        return (yv < STEP) ? 0 : yv - STEP;
    endfunction

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic req, input logic d);
        bus.move_req = req;
        bus.dir      = d;
    endtask

    // Waits (bounded) for draw_req, then pops and checks the queued position.
    task automatic wait_draw(input string tag, output int waited);
        exp_t ex;
        waited = 0;
        while (bus.draw_req !== 1'b1 && waited < 50) begin
            cycle(1);
            waited++;
        end
        if (bus.draw_req !== 1'b1) begin
            check_output({tag, "_draw_req_timeout"}, 32'(bus.draw_req), 1);
        end else if (sb_q.size() == 0) begin
            check_output({tag, "_sb_underflow"}, 32'(sb_q.size()), 1);
        end else begin
            ex = sb_q.pop_front();
            check_output({tag, "_y"}, 32'(bus.y), ex.y_exp);
            check_output({tag, "_old_y"}, 32'(bus.old_y), ex.old_exp);
        end
    endtask

    task automatic ack_draw(input string tag);
        bus.draw_ack = 1'b1;
        cycle(1);
        bus.draw_ack = 1'b0;
        check_output({tag, "_req_drop"}, 32'(bus.draw_req), 0);
    endtask

    task automatic step_once(input logic d);
        int w;
        int e;
        e = model_next(mdl_y, d);
        sb_q.push_back('{e, mdl_y});
        mdl_y = e;
        apply_stimulus(1'b1, d);
        cycle(1);
        apply_stimulus(1'b0, d);
        wait_draw("step", w);
        ack_draw("step");
        cycle(1);
    endtask

    initial begin
        int w;
        int seen;
        int t_rise[3];
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        bus.player   = 1'b1;
        bus.draw_ack = 1'b0;
        apply_stimulus(1'b1, 1'b1);
        mdl_y = 115;

        // Reset held together with a move request: reset must win.
        cycle(2);
        check_output("rst_busy_with_req", 32'(bus.busy), 0);
        check_output("rst_y_with_req", 32'(bus.y), 115);
        apply_stimulus(1'b0, 1'b1);
        reset = 1'b0;
        cycle(1);
        check_output("rst_x", 32'(bus.x), 310);
        check_output("rst_y", 32'(bus.y), 115);
        check_output("rst_old_y", 32'(bus.old_y), 115);
        check_output("rst_draw_req", 32'(bus.draw_req), 0);
        check_output("rst_busy", 32'(bus.busy), 0);
        check_output("rst_at_top", 32'(bus.at_top), 0);
        check_output("rst_at_bottom", 32'(bus.at_bottom), 0);

        // Single step with a one-cycle pulse and an ack three cycles late.
        sb_q.push_back('{125, 115});
        mdl_y = 125;
        apply_stimulus(1'b1, 1'b1);
        cycle(1);
        apply_stimulus(1'b0, 1'b1);
        wait_draw("single", w);
        check_output("single_latency", 32'(w), 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            check_output("single_req_held", 32'(bus.draw_req), 1);
        end
        ack_draw("single");
        cycle(5);
        check_output("single_idle", 32'(bus.busy), 0);
        check_output("single_no_restep", 32'(bus.y), 125);

        // Walk down to 225, then a partial step to the bottom limit.
        while (mdl_y < 225) step_once(1'b1);
        step_once(1'b1);
        check_output("clamp_at_bottom", 32'(bus.at_bottom), 1);
        apply_stimulus(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            check_output("blocked_down_busy", 32'(bus.busy), 0);
            check_output("blocked_down_req", 32'(bus.draw_req), 0);
        end
        apply_stimulus(1'b0, 1'b1);
        check_output("blocked_down_y", 32'(bus.y), 230);
        step_once(1'b0);

        // Auto-repeat upward from the reset position with immediate acks.
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        mdl_y = 115;
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back('{model_next(mdl_y, 1'b0), mdl_y});
            mdl_y = model_next(mdl_y, 1'b0);
        end
        apply_stimulus(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_draw("repeat", w);
            t_rise[k] = cyc;
            if (k > 0) check_output("repeat_spacing", 32'(t_rise[k] - t_rise[k-1]), REPEAT_TICKS + 3);
            bus.draw_ack = 1'b1;
            cycle(1);
            bus.draw_ack = 1'b0;
        end
        apply_stimulus(1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1);
            if (bus.draw_req === 1'b1) seen++;
        end
        check_output("repeat_stop_no_step", 32'(seen), 0);
        check_output("repeat_stop_y", 32'(bus.y), 85);
        check_output("repeat_stop_idle", 32'(bus.busy), 0);

        // Up to y=5, then a partial step must land on 0 rather than wrap.
        while (mdl_y > 5) step_once(1'b0);
        step_once(1'b0);
        check_output("underflow_at_top", 32'(bus.at_top), 1);
        apply_stimulus(1'b1, 1'b0);
        cycle(3);
        check_output("blocked_up_busy", 32'(bus.busy), 0);
        apply_stimulus(1'b0, 1'b0);
        check_output("blocked_up_y", 32'(bus.y), 0);

        // Reset while a draw is pending; player change mid-move waits for IDLE.
        sb_q.push_back('{model_next(mdl_y, 1'b1), mdl_y});
        mdl_y = model_next(mdl_y, 1'b1);
        apply_stimulus(1'b1, 1'b1);
        cycle(1);
        apply_stimulus(1'b0, 1'b1);
        wait_draw("mid_draw", w);
        bus.player = 1'b0;
        cycle(1);
        check_output("mid_move_x_kept", 32'(bus.x), 310);
        check_output("mid_draw_req", 32'(bus.draw_req), 1);
        reset = 1'b1;
        cycle(1);
        check_output("mid_rst_busy", 32'(bus.busy), 0);
        check_output("mid_rst_draw_req", 32'(bus.draw_req), 0);
        check_output("mid_rst_y", 32'(bus.y), 115);
        check_output("mid_rst_old_y", 32'(bus.old_y), 115);
        check_output("mid_rst_x", 32'(bus.x), 0);
        reset = 1'b0;
        bus.draw_ack = 1'b1;
        cycle(2);
        bus.draw_ack = 1'b0;
        check_output("late_ack_busy", 32'(bus.busy), 0);
        check_output("late_ack_draw_req", 32'(bus.draw_req), 0);
        check_output("late_ack_y", 32'(bus.y), 115);

        check_output("sb_drained", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
